// File: rtl/VX_tcu_pkg.sv
// rtl/VX_tcu_pkg.sv - shared types and width helpers for the TCU dot-product datapath
package VX_tcu_pkg;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
    logic divzero;
  } fedp_excep_t;

  // Aligned lane width: significand plus guard, round and sticky bits
  function automatic int calc_aw(input int w);
    return w + 3;
  endfunction

  // Sum width: enough headroom for TCK+1 aligned lanes without overflow
  function automatic int calc_sw(input int w, input int tck);
    return w + 3 + $clog2(tck + 1);
  endfunction

endpackage

// File: rtl/vx_tcu_drl_align_add_if.sv
// rtl/vx_tcu_drl_align_add_if.sv - request/result bus of the align-add stage
interface vx_tcu_drl_align_add_if import VX_tcu_pkg::*; #(
  parameter int N     = 2,
  parameter int TCK   = 2 * N,
  parameter int W     = 25,
  parameter int EXP_W = 10
) ();
  localparam int SW = calc_sw(W, TCK);

  logic                   valid_in;
  logic                   ready_in;
  logic [31:0]            req_id_in;
  logic [EXP_W-1:0]       max_exp_in;
  logic [TCK:0][7:0]      shift_amt;
  logic [TCK:0][W-1:0]    raw_sigs;
  fedp_excep_t            exceptions_in;
  logic [TCK-1:0]         lane_mask;

  logic                   valid_out;
  logic                   ready_out;
  logic [31:0]            req_id_out;
  logic [EXP_W-1:0]       max_exp_out;
  logic [SW-1:0]          sum_out;
  fedp_excep_t            exceptions_out;

  modport slave (
    input  valid_in, req_id_in, max_exp_in, shift_amt, raw_sigs, exceptions_in, lane_mask, ready_out,
    output ready_in, valid_out, req_id_out, max_exp_out, sum_out, exceptions_out
  );

  modport master (
    output valid_in, req_id_in, max_exp_in, shift_amt, raw_sigs, exceptions_in, lane_mask, ready_out,
    input  ready_in, valid_out, req_id_out, max_exp_out, sum_out, exceptions_out
  );

endinterface

// File: rtl/vx_tcu_drl_align_lane.sv
// rtl/vx_tcu_drl_align_lane.sv - one lane: GRS extension, arithmetic shift, sticky, mask
module vx_tcu_drl_align_lane import VX_tcu_pkg::*; #(
  parameter int W  = 25,
  parameter int AW = calc_aw(W)
) (
  input  logic [W-1:0]  sig_i,
  input  logic [7:0]    shift_i,
  input  logic          en_i,
  output logic [AW-1:0] aligned_o
);
  localparam logic [7:0] AW8 = 8'(AW);

  logic [AW-1:0] ext;
  logic [AW-1:0] shifted;
  logic [AW-1:0] lost_mask;
  logic          sticky;

  always_comb begin
    ext       = {sig_i, 3'b000};
    shifted   = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    // Full shift-out saturates to the sign; any nonzero input leaves a sticky trace
    if (shift_i >= AW8) begin
      shifted = {AW{sig_i[W-1]}};
      sticky  = |sig_i;
    end else begin
      shifted   = $signed(ext) >>> shift_i;
      lost_mask = ~({AW{1'b1}} << shift_i);
      sticky    = |(ext & lost_mask);
    end
    aligned_o = en_i ? (shifted | AW'(sticky)) : '0;
  end

endmodule

// File: rtl/vx_tcu_drl_align_add.sv
// rtl/vx_tcu_drl_align_add.sv - two-stage align (S1) and reduce (S2) pipeline for TCU lanes
module vx_tcu_drl_align_add import VX_tcu_pkg::*; #(
  parameter int N     = 2,
  parameter int TCK   = 2 * N,
  parameter int W     = 25,
  parameter int EXP_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_tcu_drl_align_add_if.slave    bus
);
  localparam int AW = calc_aw(W);
  localparam int SW = calc_sw(W, TCK);

  logic [TCK:0]          lane_en;
  logic [TCK:0][AW-1:0]  aligned;
  logic [SW-1:0]         sum_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [TCK:0][AW-1:0]  s1_lanes_q;
  logic [31:0]           s1_id_q;
  logic [EXP_W-1:0]      s1_exp_q;
  fedp_excep_t           s1_exc_q;

  logic                  s2_valid_q, s2_valid_d;
  logic [SW-1:0]         s2_sum_q;
  logic [31:0]           s2_id_q;
  logic [EXP_W-1:0]      s2_exp_q;
  fedp_excep_t           s2_exc_q;

  logic                  s2_ready;
  logic                  s1_advance;
  logic                  accept;

  assign lane_en = {1'b1, bus.lane_mask};

  for (genvar i = 0; i <= TCK; i++) begin : g_lane
    vx_tcu_drl_align_lane #(.W(W), .AW(AW)) u_lane (
      .sig_i     (bus.raw_sigs[i]),
      .shift_i   (bus.shift_amt[i]),
      .en_i      (lane_en[i]),
      .aligned_o (aligned[i])
    );
  end

  // ready_in depends only on stage state and ready_out, never on valid_in
  assign s2_ready     = !s2_valid_q || bus.ready_out;
  assign s1_advance   = s1_valid_q && s2_ready;
  assign bus.ready_in = !s1_valid_q || s1_advance;
  assign accept       = bus.valid_in && bus.ready_in;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (bus.ready_in) s1_valid_d = bus.valid_in;
    if (s2_ready)     s2_valid_d = s1_valid_q;
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i <= TCK; i++) begin
      sum_d = sum_d + SW'($signed(s1_lanes_q[i]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_lanes_q <= aligned;
      s1_id_q    <= bus.req_id_in;
      s1_exp_q   <= bus.max_exp_in;
      s1_exc_q   <= bus.exceptions_in;
    end
    if (s1_advance) begin
      s2_sum_q <= sum_d;
      s2_id_q  <= s1_id_q;
      s2_exp_q <= s1_exp_q;
      s2_exc_q <= s1_exc_q;
    end
  end

  assign bus.valid_out      = s2_valid_q;
  assign bus.sum_out        = s2_sum_q;
  assign bus.req_id_out     = s2_id_q;
  assign bus.max_exp_out    = s2_exp_q;
  assign bus.exceptions_out = s2_exc_q;

endmodule

// File: tb/tb_vx_tcu_drl_align_add.sv
// tb/tb_vx_tcu_drl_align_add.sv - directed self-checking bench for vx_tcu_drl_align_add
module tb_vx_tcu_drl_align_add;
  localparam int N   = 2;
  localparam int TCK = 2 * N;
  localparam int W   = 25;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  vx_tcu_drl_align_add_if #(.N(N)) bus ();

  vx_tcu_drl_align_add #(.N(N)) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_lanes();
    bus.raw_sigs  = '0;
    bus.shift_amt = '0;
    bus.lane_mask = '0;
  endtask

  // Issue one request into an empty pipeline and check it two cycles later
  task automatic single(input string tag, input logic [31:0] id, input logic [9:0] mexp,
                        input logic [4:0] exc, input logic signed [63:0] exp_sum);
    bus.req_id_in     = id;
    bus.max_exp_in    = mexp;
    bus.exceptions_in = exc;
    bus.valid_in      = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    check({tag, "_early"}, bus.valid_out, 0);
    @(negedge clk);
    check({tag, "_valid"}, bus.valid_out, 1);
    check({tag, "_sum"}, $signed(bus.sum_out), exp_sum);
    check({tag, "_id"}, bus.req_id_out, id);
    check({tag, "_exp"}, bus.max_exp_out, mexp);
    check({tag, "_exc"}, bus.exceptions_out, exc);
    @(negedge clk);
    check({tag, "_drain"}, bus.valid_out, 0);
  endtask

  initial begin
    int k;
    int got;
    int stale;
    logic acc;

    checks = 0;
    failures = 0;
    clk = 1'b0;
    reset_n = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_out = 1'b1;
    bus.req_id_in = '0;
    bus.max_exp_in = '0;
    bus.exceptions_in = '0;
    clr_lanes();

    repeat (3) @(negedge clk);
    check("reset_valid_out", bus.valid_out, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_ready_in", bus.ready_in, 1);
    check("reset_no_output", bus.valid_out, 0);

    // Lane0=1, C=2, lane1 masked off despite a nonzero value
    clr_lanes();
    bus.raw_sigs[0] = 25'd1;
    bus.raw_sigs[1] = 25'd7;
    bus.raw_sigs[TCK] = 25'd2;
    bus.lane_mask = 4'b0001;
    single("basic", 32'h45, 10'h155, 5'b10101, 24);

    clr_lanes();
    bus.raw_sigs[0] = 25'h1FFFFFF;
    bus.shift_amt[0] = 8'd40;
    bus.lane_mask = 4'b0001;
    single("neg_big_shift", 32'h46, 10'h3, 5'b0, -1);

    clr_lanes();
    bus.raw_sigs[0] = 25'd5;
    bus.shift_amt[0] = 8'd1;
    bus.lane_mask = 4'b0001;
    single("shift1", 32'h47, 10'h0, 5'b0, 20);

    bus.shift_amt[0] = 8'd4;
    single("shift4_sticky", 32'h48, 10'h0, 5'b0, 3);

    // Positive value fully shifted out leaves only the sticky bit; C lane ignores mask
    clr_lanes();
    bus.raw_sigs[TCK] = 25'd5;
    bus.shift_amt[TCK] = 8'd40;
    single("pos_big_shift", 32'h49, 10'h1, 5'b0, 1);

    clr_lanes();
    bus.raw_sigs[2] = 25'h1FFFFF8;
    bus.shift_amt[2] = 8'd2;
    bus.raw_sigs[3] = 25'd3;
    bus.lane_mask = 4'b1100;
    single("neg_shift", 32'h4A, 10'h2, 5'b0, 8);

    clr_lanes();
    for (int i = 0; i <= TCK; i++) bus.raw_sigs[i] = 25'h0FFFFFF;
    bus.lane_mask = 4'b1111;
    single("max_pos", 32'h4B, 10'h3FF, 5'b11111, 671088600);

    for (int i = 0; i <= TCK; i++) bus.raw_sigs[i] = 25'h1000000;
    single("max_neg", 32'h4C, 10'h0, 5'b0, -671088640);

    // Back-to-back stream with ready_out held high
    clr_lanes();
    bus.lane_mask = 4'b0001;
    bus.ready_out = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i >= 2 && i < 10) begin
        check("b2b_valid", bus.valid_out, 1);
        check("b2b_id", bus.req_id_out, 100 + i - 2);
        check("b2b_sum", $signed(bus.sum_out), (i - 2) * 8);
      end
      if (i < 8) begin
        check("b2b_ready_in", bus.ready_in, 1);
        bus.valid_in = 1'b1;
        bus.req_id_in = 32'(100 + i);
        bus.raw_sigs[0] = 25'(i);
      end else begin
        bus.valid_in = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_idle", bus.valid_out, 0);

    // Stall: ready_out low for 5 cycles while 3 requests are offered
    bus.ready_out = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      if (c >= 2) begin
        check("stall_ready_in", bus.ready_in, 0);
        check("stall_valid", bus.valid_out, 1);
        check("stall_id", bus.req_id_out, 200);
        check("stall_sum", $signed(bus.sum_out), 80);
      end
      bus.valid_in = (k < 3);
      bus.req_id_in = 32'(200 + k);
      bus.raw_sigs[0] = 25'(k + 10);
      #1 acc = bus.ready_in && bus.valid_in;
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
    end
    check("stall_accepted", k, 2);
    bus.ready_out = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.valid_out) begin
        check("drain_id", bus.req_id_out, 200 + got);
        check("drain_sum", $signed(bus.sum_out), (got + 10) * 8);
        got++;
      end
      bus.valid_in = (k < 3);
      bus.req_id_in = 32'(200 + k);
      bus.raw_sigs[0] = 25'(k + 10);
      #1 acc = bus.ready_in && bus.valid_in;
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
    end
    check("drain_count", got, 3);
    check("drain_accepted", k, 3);

    // Reset with both stages full
    bus.ready_out = 1'b0;
    bus.valid_in = 1'b1;
    bus.req_id_in = 32'h300;
    @(negedge clk);
    bus.req_id_in = 32'h301;
    @(negedge clk);
    bus.valid_in = 1'b0;
    check("full_valid", bus.valid_out, 1);
    check("full_ready_in", bus.ready_in, 0);
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", bus.valid_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.ready_out = 1'b1;
    #1;
    check("post_reset_ready_in", bus.ready_in, 1);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.valid_out !== 1'b0) stale++;
    end
    check("no_stale_result", stale, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_tcu_drl_align_add.md
VX_TCU_DRL_ALIGN_ADD -- requirements
Module: vx_tcu_drl_align_add

Interface
REQ-001 SHALL have parameter N, default 2: number of 32-bit input registers per operand.
REQ-002 SHALL have parameter TCK, default 2*N: number of physical product lanes; lane TCK is the C-addend lane.
REQ-003 SHALL have parameter W, default 25: width of the signed significands.
REQ-004 SHALL have parameter EXP_W, default 10: exponent width.
REQ-005 SHALL derive constants AW = W+3 (guard, round, sticky) and SW = AW + clog2(TCK+1) (sum width).
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port valid_in, input, 1: upstream request valid.
REQ-009 SHALL have port ready_in, output, 1: block can accept a request.
REQ-010 SHALL have port req_id_in, input, 32: request tag.
REQ-011 SHALL have port max_exp_in, input, EXP_W: group maximum exponent.
REQ-012 SHALL have port shift_amt, input, (TCK+1)x8: per-lane right-shift amount.
REQ-013 SHALL have port raw_sigs, input, (TCK+1)xW: per-lane significands, two's complement.
REQ-014 SHALL have port exceptions_in, input, fedp_excep_t: exception flags.
REQ-015 SHALL have port lane_mask, input, TCK: active product lanes; the C lane is always active.
REQ-016 SHALL have port valid_out, output, 1: result valid.
REQ-017 SHALL have port ready_out, input, 1: downstream accepts the result.
REQ-018 SHALL have port req_id_out, output, 32: tag of the result.
REQ-019 SHALL have port max_exp_out, output, EXP_W: exponent of the result.
REQ-020 SHALL have port sum_out, output, SW: signed aligned sum.
REQ-021 SHALL have port exceptions_out, output, fedp_excep_t: flags carried through with the result.

Function
REQ-022 SHALL be a two-stage pipeline: S1 aligns and masks the lanes and registers them; S2 reduces the lanes to a sum and registers it.
REQ-023 SHALL have latency of exactly 2 cycles from an accepted input (valid_in && ready_in) to valid_out when no stall occurs.
REQ-024 Alignment SHALL sign-extend each lane to AW bits with the significand placed above the 3 GRS bits, then arithmetic-right-shift it by shift_amt.
REQ-025 Alignment SHALL OR all bits shifted out into the LSB as the sticky bit.
REQ-026 A shift of AW or more SHALL produce all sign bits, with sticky set if the original value was nonzero.
REQ-027 Lane i < TCK with lane_mask[i]=0 SHALL contribute exactly zero, sticky included.
REQ-028 The S2 sum SHALL be the exact signed sum of the TCK+1 aligned lanes at SW bits, with no overflow possible.
REQ-029 req_id, max_exp and exceptions SHALL travel through both stages alongside their data, unmodified.
REQ-030 Each stage SHALL hold a valid bit.
REQ-031 S2 SHALL load when it is empty or when (valid_out && ready_out).
REQ-032 S1 SHALL load when it is empty or when it advances into S2.
REQ-033 ready_in SHALL equal !s1_valid || s1_advance, and SHALL have no combinational path from valid_in.
REQ-034 While valid_out=1 && ready_out=0, all outputs SHALL remain stable.
REQ-035 Under a simultaneous accept, S1-to-S2 transfer and output drain, the pipeline SHALL sustain one result per cycle with no bubble.
REQ-036 With both stages full and ready_out=0, ready_in SHALL be 0 and no data SHALL be lost or duplicated.
REQ-037 Non-zero exceptions_in SHALL NOT alter the datapath; the sum SHALL still be produced.

Reset
REQ-038 On reset=0, both stage valid bits SHALL clear asynchronously.
REQ-039 During reset, valid_out SHALL be 0 and ready_in SHALL be 1 after reset is released.
REQ-040 Data registers SHALL need no reset; sum_out, max_exp_out, req_id_out and exceptions_out SHALL be don't-care while valid_out=0.
REQ-041 Reset asserted mid-operation SHALL discard in-flight requests, with no output after release until new input arrives.

Structure
REQ-042 fedp_excep_t and the AW/SW derivation helpers SHALL reside in VX_tcu_pkg.
REQ-043 The per-lane aligner SHALL be a sub-module, vx_tcu_drl_align_lane (shift, sticky, mask), instantiated TCK+1 times.
REQ-044 The reduction SHALL be a plain adder tree inside S2.

Verification
REQ-045 Single request with W=25, all shifts 0, lane0=1, C lane=2, others masked -> after 2 cycles sum_out = 3<<3 (24), same req_id.
REQ-046 Lane value -1 with shift 40, all other lanes 0 -> that lane's contribution is all-ones (-1 with sticky), so sum_out = -1.
REQ-047 Lane value 0x5 with shift 1 -> aligned value (0x5<<3)>>1 = 0x14 with sticky 0; with shift 4 -> 0x2 with sticky 1, giving 0x3.
REQ-048 Back-to-back 8 requests with ready_out=1 -> 8 results on consecutive cycles, in order, ready_in continuously 1.
REQ-049 ready_out held 0 for 5 cycles with 3 requests offered -> ready_in drops after 2 are accepted, outputs stay stable, and all 3 results emerge in order after release.
REQ-050 reset asserted with both stages full -> valid_out=0 immediately; after release, no stale result appears.
